// File: rtl/svec_node_pkg.sv
// svec_node_pkg: shared AM codes, CR/CSR register addresses and FSM state type for the SVEC node front end
package svec_node_pkg;
    localparam logic [5:0] AM_CSR   = 6'h2F;
    localparam logic [5:0] AM_A24_U = 6'h39;
    localparam logic [5:0] AM_A24_S = 6'h3D;
    localparam logic [5:0] AM_A32_U = 6'h09;
    localparam logic [5:0] AM_A32_S = 6'h0D;
    localparam logic [18:0] ADER_BASE    = 19'h7FF63;
    localparam logic [18:0] ADER_STRIDE  = 19'h10;
    localparam logic [18:0] BIT_SET_ADDR = 19'h7FFFB;
    localparam logic [18:0] BIT_CLR_ADDR = 19'h7FFF7;
    localparam logic [18:0] WB32_ADDR    = 19'h7FF33;
    typedef enum logic [1:0] {IDLE, CSR, WB, RESP} state_t;
    function automatic logic [18:0] ader_addr(input int f, input int b);
        return ADER_BASE + ADER_STRIDE * 19'(f) + 19'(4 * b);
    endfunction
endpackage

// File: rtl/svec_crcsr_regs.sv
// svec_crcsr_regs: CR/CSR register file (ADERs, bit register, WB32) and function address match
module svec_crcsr_regs
    import svec_node_pkg::*;
#(
    parameter int g_a24_win_bits = 20,
    parameter int g_a32_win_bits = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [18:0]              csr_addr,
    input  logic [31:g_a24_win_bits] hi_addr,
    input  logic [7:0]               wdata,
    input  logic [5:0]               am,
    output logic [7:0]               rdata,
    output logic                     module_en,
    output logic                     hit
);
    logic [31:0] ader [2];
    logic [7:0]  bits;
    logic        wb32;
    logic [1:0]  match;
    logic        a24;
    logic        a32;
    assign a24 = am == AM_A24_U || am == AM_A24_S;
    assign a32 = am == AM_A32_U || am == AM_A32_S;
    assign module_en = bits[4];
    assign hit = |match;
    always_ff @(posedge clk) begin
        if (rst) begin
            ader <= '{default: '0};
            bits <= '0;
            wb32 <= 1'b0;
        end else if (we) begin
            if (csr_addr == BIT_SET_ADDR) bits <= bits | wdata;
            if (csr_addr == BIT_CLR_ADDR) bits <= bits & ~wdata;
            if (csr_addr == WB32_ADDR) wb32 <= wdata[0];
            for (int f = 0; f < 2; f++)
                for (int b = 0; b < 4; b++)
                    if (csr_addr == ader_addr(f, b)) ader[f][31-8*b -: 8] <= wdata;
        end
    end
    // Byte 0 of an ADER is its MSB; an AM field of 0 never matches a real AM
    always_comb begin
        rdata = (csr_addr == BIT_SET_ADDR || csr_addr == BIT_CLR_ADDR) ? bits :
                (csr_addr == WB32_ADDR) ? {7'b0, wb32} : 8'h00;
        match = '0;
        for (int f = 0; f < 2; f++) begin
            for (int b = 0; b < 4; b++)
                if (csr_addr == ader_addr(f, b)) rdata = ader[f][31-8*b -: 8];
            match[f] = !ader[f][0] && ader[f][7:2] == am &&
                       ((a24 && hi_addr[23:g_a24_win_bits] == ader[f][23:g_a24_win_bits]) ||
                        (a32 && hi_addr[31:g_a32_win_bits] == ader[f][31:g_a32_win_bits]));
        end
    end
endmodule

// File: rtl/svec_node_top.sv
// svec_node_top: host bus front end serving CR/CSR space and bridging matched function accesses to Wishbone
module svec_node_top
    import svec_node_pkg::*;
#(
    parameter int g_a24_win_bits = 20,
    parameter int g_a32_win_bits = 24,
    parameter int g_wb_timeout   = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        bus_req_i,
    input  logic        bus_we_i,
    input  logic [5:0]  bus_am_i,
    input  logic        bus_d08_i,
    input  logic [31:0] bus_addr_i,
    input  logic [31:0] bus_data_i,
    output logic [31:0] bus_data_o,
    output logic        bus_ack_o,
    output logic        bus_berr_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        module_en_o
);
    localparam int CW = $clog2(g_wb_timeout + 1);
    state_t state, state_nx;
    logic          is_a24;
    logic          take;
    logic          go_csr;
    logic          go_wb;
    logic          fail;
    logic          done;
    logic          module_en;
    logic          hit;
    logic [7:0]    csr_rdata;
    logic [CW-1:0] cnt;
    assign is_a24 = bus_am_i == AM_A24_U || bus_am_i == AM_A24_S;
    assign take = state == IDLE && bus_req_i;
    assign go_csr = bus_am_i == AM_CSR && bus_d08_i;
    assign go_wb = hit && module_en && !bus_d08_i;
    assign fail = wb_err_i || cnt == CW'(g_wb_timeout - 1);
    assign done = state == WB && (wb_ack_i || fail);
    assign wb_stb_o = wb_cyc_o;
    assign wb_sel_o = {4{wb_cyc_o}};
    assign module_en_o = module_en;
    svec_crcsr_regs #(
        .g_a24_win_bits(g_a24_win_bits),
        .g_a32_win_bits(g_a32_win_bits)
    ) u_regs (
        .clk      (clk_i),
        .rst      (rst_i),
        .we       (take && go_csr && bus_we_i),
        .csr_addr (bus_addr_i[18:0]),
        .hi_addr  (bus_addr_i[31:g_a24_win_bits]),
        .wdata    (bus_data_i[7:0]),
        .am       (bus_am_i),
        .rdata    (csr_rdata),
        .module_en(module_en),
        .hit      (hit)
    );
    always_ff @(posedge clk_i) state <= rst_i ? IDLE : state_nx;
    always_comb begin
        state_nx = (state == IDLE) ? (bus_req_i ? (go_csr ? CSR : go_wb ? WB : RESP) : IDLE) :
                   (state == WB) ? (done ? RESP : WB) : IDLE;
    end
    // err beats ack when both arrive; timeout counts only while the cycle is open
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bus_data_o <= '0;
            bus_ack_o  <= 1'b0;
            bus_berr_o <= 1'b0;
            wb_cyc_o   <= 1'b0;
            wb_we_o    <= 1'b0;
            wb_adr_o   <= '0;
            wb_dat_o   <= '0;
            cnt        <= '0;
        end else begin
            bus_ack_o  <= (take && go_csr) || (done && !fail);
            bus_berr_o <= (take && !go_csr && !go_wb) || (done && fail);
            cnt        <= state == WB ? cnt + 1'b1 : '0;
            if (take && go_csr) bus_data_o <= {24'h0, csr_rdata};
            if (done && !fail) bus_data_o <= wb_dat_i;
            if (take && go_wb) begin
                wb_cyc_o <= 1'b1;
                wb_we_o  <= bus_we_i;
                wb_dat_o <= bus_data_i;
                wb_adr_o <= is_a24 ? 32'(bus_addr_i[g_a24_win_bits-1:2]) : 32'(bus_addr_i[g_a32_win_bits-1:2]);
            end else if (done) begin
                wb_cyc_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_svec_node_top.sv
// tb_svec_node_top: scoreboard bench for the SVEC node front end with a Wishbone slave model
module tb_svec_node_top;
    typedef struct {bit berr; bit chkd; logic [31:0] data; int cyc;} exp_t;
    typedef struct {logic we; logic [31:0] adr; logic [31:0] dat;} wexp_t;
    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        bus_req_i = 1'b0;
    logic        bus_we_i = 1'b0;
    logic [5:0]  bus_am_i = '0;
    logic        bus_d08_i = 1'b0;
    logic [31:0] bus_addr_i = '0;
    logic [31:0] bus_data_i = '0;
    logic [31:0] bus_data_o;
    logic        bus_ack_o;
    logic        bus_berr_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;
    logic        module_en_o;
    exp_t  q[$];
    wexp_t wq[$];
    exp_t  me;
    wexp_t mw;
    int errors = 0, checks = 0, cyc = 0, resp_cnt = 0, cyc_hi = 0;
    int wb_mode = 0, wb_delay = 0;
    logic [31:0] wb_rdata = '0;
    svec_node_top dut (
        .clk_i(clk), .rst_i(rst_i), .bus_req_i(bus_req_i), .bus_we_i(bus_we_i), .bus_am_i(bus_am_i),
        .bus_d08_i(bus_d08_i), .bus_addr_i(bus_addr_i), .bus_data_i(bus_data_i), .bus_data_o(bus_data_o),
        .bus_ack_o(bus_ack_o), .bus_berr_o(bus_berr_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .module_en_o(module_en_o)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (wb_cyc_o) cyc_hi <= cyc_hi + 1;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    // Response monitor: kind, arrival cycle and read data against the scoreboard
    initial forever begin
        @(negedge clk);
        if (bus_ack_o || bus_berr_o) begin
            resp_cnt++;
            if (q.size() == 0) chk("unexpected_resp", {30'b0, bus_ack_o, bus_berr_o}, 32'h0);
            else begin
                me = q.pop_front();
                chk("resp_kind", {30'b0, bus_ack_o, bus_berr_o}, me.berr ? 32'h1 : 32'h2);
                chk("resp_cycle", cyc, me.cyc);
                if (me.chkd) chk("resp_data", bus_data_o, me.data);
            end
        end
    end
    // Wishbone slave: 0 ack, 1 silent, 2 err, 3 ack+err, after wb_delay cycles
    initial forever begin
        @(negedge clk);
        if (wb_cyc_o && wb_stb_o) begin
            if (wq.size() == 0) chk("unexpected_wb", {31'b0, wb_cyc_o}, 32'h0);
            else begin
                mw = wq.pop_front();
                chk("wb_adr", wb_adr_o, mw.adr);
                chk("wb_we", {31'b0, wb_we_o}, {31'b0, mw.we});
                chk("wb_dat", wb_dat_o, mw.dat);
                chk("wb_sel", {28'b0, wb_sel_o}, 32'hF);
            end
            if (wb_mode == 1) begin
                for (int i = 0; i < 1000 && wb_cyc_o; i++) @(negedge clk);
            end else begin
                repeat (wb_delay) @(negedge clk);
                wb_dat_i = wb_rdata;
                wb_ack_i = wb_mode != 2;
                wb_err_i = wb_mode >= 2;
                @(negedge clk);
                wb_ack_i = 1'b0;
                wb_err_i = 1'b0;
            end
        end
    end
    task automatic issue(input logic we, input logic [5:0] am, input logic d08, input logic [31:0] a,
                         input logic [31:0] d, input bit push, input bit berr, input bit chkd,
                         input logic [31:0] data, input int lat);
        @(negedge clk);
        if (push) q.push_back('{berr, chkd, data, cyc + lat});
        bus_req_i = 1'b1; bus_we_i = we; bus_am_i = am; bus_d08_i = d08; bus_addr_i = a; bus_data_i = d;
        @(negedge clk);
        bus_req_i = 1'b0;
    endtask
    task automatic wait_resp(input int n0, input int limit);
        for (int i = 0; i < limit && resp_cnt == n0; i++) @(negedge clk);
        chk("resp_arrived", {31'b0, resp_cnt != n0}, 32'h1);
        @(negedge clk);
    endtask
    task automatic txn(input logic we, input logic [5:0] am, input logic d08, input logic [31:0] a,
                       input logic [31:0] d, input bit berr, input bit chkd, input logic [31:0] data, input int lat);
        int n0 = resp_cnt;
        issue(we, am, d08, a, d, 1, berr, chkd, data, lat);
        wait_resp(n0, lat + 20);
    endtask
    task automatic csr_wr(input logic [31:0] a, input logic [7:0] d);
        txn(1, 6'h2F, 1, a, {24'h0, d}, 0, 0, 0, 1);
    endtask
    task automatic csr_rd(input logic [31:0] a, input logic [7:0] d);
        txn(0, 6'h2F, 1, a, 0, 0, 1, {24'h0, d}, 1);
    endtask
    task automatic berr_chk(input string name, input logic [5:0] am, input logic d08, input logic [31:0] a);
        int h0 = cyc_hi;
        txn(0, am, d08, a, 0, 1, 0, 0, 1);
        chk(name, cyc_hi - h0, 0);
    endtask
    task automatic wb_txn(input logic we, input logic [5:0] am, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] adr, input int mode, input int delay, input logic [31:0] rdata,
                          input bit berr, input int lat);
        wb_mode = mode; wb_delay = delay; wb_rdata = rdata;
        wq.push_back('{we, adr, d});
        txn(we, am, 0, a, d, berr, !berr && !we, rdata, lat);
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        int n0, h0;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        chk("reset_ack", {31'b0, bus_ack_o}, 0);
        chk("reset_berr", {31'b0, bus_berr_o}, 0);
        chk("reset_cyc", {31'b0, wb_cyc_o}, 0);
        chk("reset_en", {31'b0, module_en_o}, 0);
        chk("reset_data", bus_data_o, 0);
        csr_rd(32'h7FFFB, 8'h00);
        chk("en_after_reset", {31'b0, module_en_o}, 0);
        csr_wr(32'h7FF73, 8'h00); csr_wr(32'h7FF77, 8'hC0); csr_wr(32'h7FF7B, 8'h00); csr_wr(32'h7FF7F, 8'hE4);
        csr_wr(32'h7FF63, 8'h00); csr_wr(32'h7FF67, 8'h00); csr_wr(32'h7FF6B, 8'h00); csr_wr(32'h7FF6F, 8'h01);
        csr_wr(32'h7FF33, 8'h01);
        csr_wr(32'h7FFFB, 8'h10);
        chk("en_set", {31'b0, module_en_o}, 1);
        csr_rd(32'h7FF73, 8'h00); csr_rd(32'h7FF77, 8'hC0); csr_rd(32'h7FF7B, 8'h00); csr_rd(32'h7FF7F, 8'hE4);
        csr_rd(32'h7FF6F, 8'h01);
        csr_rd(32'h7FF33, 8'h01);
        csr_rd(32'h7FFFB, 8'h10);
        csr_rd(32'h7FFF7, 8'h10);
        csr_rd(32'h12345, 8'h00);
        csr_wr(32'h7FF33, 8'hFF);
        csr_rd(32'h7FF33, 8'h01);
        berr_chk("csr_d32_no_cyc", 6'h2F, 0, 32'h7FFFB);
        wb_txn(1, 6'h39, 32'hCD0000, 32'h1, 32'h34000, 0, 3, 32'h0, 0, 5);
        wb_txn(0, 6'h39, 32'hCD0004, 32'h0, 32'h34001, 0, 3, 32'hDEADBEEF, 0, 5);
        berr_chk("a24_miss_no_cyc", 6'h39, 0, 32'hB00000);
        berr_chk("a24_am_mismatch_no_cyc", 6'h3D, 0, 32'hCD0000);
        csr_wr(32'h7FF63, 8'h12); csr_wr(32'h7FF6F, 8'h24);
        wb_txn(0, 6'h09, 32'h12345678, 32'h0, 32'h000D159E, 0, 0, 32'hCAFEF00D, 0, 2);
        berr_chk("a32_miss_no_cyc", 6'h09, 0, 32'h13000000);
        wb_txn(1, 6'h39, 32'hCD0008, 32'h55, 32'h34002, 2, 1, 32'h0, 1, 3);
        wb_txn(0, 6'h39, 32'hCD000C, 32'h0, 32'h34003, 3, 0, 32'h0, 1, 2);
        csr_wr(32'h7FFF7, 8'h10);
        chk("en_cleared", {31'b0, module_en_o}, 0);
        berr_chk("disabled_no_cyc", 6'h39, 0, 32'hCD0000);
        csr_wr(32'h7FFFB, 8'h10);
        berr_chk("d08_func_no_cyc", 6'h39, 1, 32'hCD0000);
        berr_chk("bad_am_no_cyc", 6'h3F, 0, 32'hCD0000);
        n0 = resp_cnt; h0 = cyc_hi;
        wb_mode = 1;
        wq.push_back('{1'b0, 32'h0, 32'h0});
        issue(0, 6'h39, 0, 32'hC00000, 0, 1, 1, 0, 0, 257);
        repeat (50) @(negedge clk);
        issue(0, 6'h2F, 1, 32'h7FFFB, 0, 0, 0, 0, 0, 0);
        wait_resp(n0, 400);
        chk("timeout_cyc_len", cyc_hi - h0, 256);
        repeat (5) @(negedge clk);
        chk("no_extra_resp", resp_cnt, n0 + 1);
        n0 = resp_cnt;
        wq.push_back('{1'b0, 32'h0, 32'h0});
        issue(0, 6'h39, 0, 32'hC00000, 0, 0, 0, 0, 0, 0);
        repeat (5) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        chk("reset_drops_cyc", {31'b0, wb_cyc_o}, 0);
        chk("reset_clears_en", {31'b0, module_en_o}, 0);
        repeat (3) @(negedge clk);
        chk("reset_no_resp", resp_cnt, n0);
        csr_rd(32'h7FFFB, 8'h00);
        csr_rd(32'h7FF7F, 8'h00);
        chk("scoreboard_empty", q.size(), 0);
        chk("wb_queue_empty", wq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/svec_node_top.md
Name: svec_node_top

Overview:
- Host-side front end of the SVEC node core.
- Takes single, already-synchronised host bus cycles and serves the VME64x-style CR/CSR configuration space: function ADERs, BIT_SET/BIT_CLR and WB32.
- Decodes A24/A32 D32 accesses against the programmed ADERs and bridges matching accesses to a Wishbone master port. The node CPU CSR and the other peripherals sit on that port.

Parameters:
- g_a24_win_bits, 20, A24 window size in address bits (1 MiB; func base compared on addr[23:20]).
- g_a32_win_bits, 24, A32 window size in address bits.
- g_wb_timeout, 256, cycles without wb_ack_i/wb_err_i before the bridge aborts.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous active-high reset.
- bus_req_i  in  1  one-cycle access request strobe.
- bus_we_i  in  1  1 = write.
- bus_am_i  in  6  address modifier.
- bus_d08_i  in  1  1 = D08 (byte 3) access, 0 = D32.
- bus_addr_i  in  32  byte address.
- bus_data_i  in  32  write data (D08 uses bits 7:0).
- bus_data_o  out  32  read data, valid with bus_ack_o.
- bus_ack_o  out  1  one-cycle completion pulse.
- bus_berr_o  out  1  one-cycle bus-error pulse.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone master control.
- wb_adr_o  out  32  word address within the function window.
- wb_dat_o  out  32  Wishbone write data.
- wb_sel_o  out  4  byte select (always 4'hF).
- wb_dat_i  in  32  Wishbone read data.
- wb_ack_i, wb_err_i  in  1 each  Wishbone slave response.
- module_en_o  out  1  BIT_SET bit 4 (module enable).

Behaviour:
- Reset values:
  - All outputs 0.
  - ADER0/ADER1 = 0 (AM field 0 never matches, so functions are disabled).
  - Bit register = 0; WB32 = 0.
  - An in-flight Wishbone cycle is dropped with no bus response.
- Request handling:
  - FSM states: IDLE, CSR, WB, RESP.
  - bus_req_i is sampled only in IDLE; requests arriving in any other state are ignored (no ack, no berr).
- CR/CSR space (AM = 0x2F):
  - Uses addr[18:0]; D08 only (D32 gives berr).
  - Response is an ack one cycle after the request; read data is in bus_data_o[7:0] with the upper bits 0.
  - ADER f, byte b (f = 0..1, b = 0..3) lives at 0x7FF63 + f*0x10 + 4*b; b = 0 is the MSB (bits 31:24). Read/write.
  - 0x7FFFB BIT_SET: write ORs the data into the bit register. 0x7FFF7 BIT_CLR: write clears the ones. Reading either returns the bit register.
  - Bit register bit 4 = module_en_o.
  - 0x7FF33 WB32: bit 0 read/write, other bits read 0. Function accesses are D32 regardless of WB32.
  - Any other CR/CSR address: reads return 0 with ack; writes are ignored with ack.
- Function decode (module_en_o = 1, D32 only):
  - Function f matches when ADERf[0] = 0 and ADERf[7:2] = bus_am_i.
  - For A24 (AM 0x39/0x3D), addr[23:g_a24_win_bits] must also equal ADERf[23:g_a24_win_bits].
  - For A32 (AM 0x09/0x0D), addr[31:g_a32_win_bits] must also equal ADERf[31:g_a32_win_bits].
  - Func0 has priority when both match.
- Error responses: berr one cycle after the request for any of
  - no function match;
  - module disabled;
  - D08 access to function space;
  - an AM that is neither CR/CSR nor a recognised function AM.
- Wishbone bridge:
  - The cycle after the request: cyc = stb = 1, we = bus_we_i, dat_o = bus_data_i, sel = F.
  - wb_adr_o = (addr mod 2^win) >> 2, zero-extended.
  - cyc/stb stay asserted until wb_ack_i, wb_err_i or timeout, then drop in the next cycle.
  - On wb_ack_i: bus_ack_o pulses the cycle after, with bus_data_o = wb_dat_i latched on the ack.
  - On wb_err_i, or g_wb_timeout cycles with no response: bus_berr_o pulses the cycle after.
  - If ack and err arrive together, err wins.
- A reset asserted mid-operation returns the FSM to IDLE within one cycle.

Decomposition:
- Package svec_node_pkg holds:
  - AM constants (0x2F, 0x39, 0x3D, 0x09, 0x0D);
  - CSR addresses (ADER base 0x7FF63, stride 0x10, BIT_SET 0x7FFFB, BIT_CLR 0x7FFF7, WB32 0x7FF33);
  - the FSM state enum.
- One sub-module, svec_crcsr_regs: CSR register file plus function-match logic. The top holds the FSM and the Wishbone bridge.

Test Plan:
1. After reset, CR/CSR D08 read of 0x7FFFB -> bus_ack_o one cycle later, data 0x00, module_en_o = 0.
2. Program ADER1 bytes 00,C0,00,E4 at 0x7FF73/77/7B/7F; ADER0 bytes 00,00,00,01; write 1 to 0x7FF33; write 0x10 to 0x7FFFB -> module_en_o = 1, ADER1 bytes read back as 00,C0,00,E4, 0x7FF33 reads 1.
3. A24 D32 write of 0x00000001 to 0xCD0000, wb_ack_i 3 cycles after stb -> wb_adr_o = 0x34000, wb_we_o = 1, wb_dat_o = 1, bus_ack_o pulse on the cycle after wb_ack_i.
4. A24 D32 read of 0xCD0004 with wb_dat_i = 0xDEADBEEF -> wb_adr_o = 0x34001, bus_data_o = 0xDEADBEEF.
5. Three cases, each giving bus_berr_o one cycle after the request with wb_cyc_o staying 0:
   - A24 access to 0xB00000;
   - write 0x10 to 0x7FFF7, then access 0xCD0000;
   - D08 access to 0xCD0000.
6. A24 read of 0xC00000 with no wb_ack_i -> cyc drops after 256 cycles and bus_berr_o pulses; a new bus_req_i issued mid-transfer is ignored.
